// File: rtl/rf_wb_scheduler.sv
// Register-file write-port scheduler: arbitrates pipeline (A) and long-latency (B) write-backs
// and keeps a scoreboard of destinations with outstanding long-latency results.
module rf_wb_scheduler #(
  parameter int STARVE_MAX = 4,
  parameter int CNT_W      = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [4:0]  a_rd,
  input  logic [31:0] a_data,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_rd,
  input  logic [31:0] b_data,
  input  logic        iss_valid,
  input  logic [4:0]  iss_rd,
  output logic        iss_ready,
  input  logic [4:0]  rs1_index,
  input  logic [4:0]  rs2_index,
  output logic        rs1_busy,
  output logic        rs2_busy,
  output logic        sb_empty,
  output logic        wb_en,
  output logic [4:0]  rd_index,
  output logic [31:0] wb_data
);

  logic [CNT_W-1:0] starve_cnt;
  logic [31:0]      busy;
  logic [31:0]      busy_nxt;
  logic             force_b;
  logic             grant_a;
  logic             grant_b;
  logic             vld_p1;
  logic [4:0]       rd_p1;
  logic [31:0]      data_p1;
  logic [4:0]       sel_rd;
  logic [31:0]      sel_data;

  assign force_b   = b_valid && (starve_cnt == CNT_W'(STARVE_MAX));
  assign grant_b   = force_b || (b_valid && !a_valid);
  assign grant_a   = a_valid && !force_b;
  assign a_ready   = !force_b;
  assign b_ready   = grant_b;
  assign iss_ready = !busy[iss_rd];
  assign rs1_busy  = busy[rs1_index];
  assign rs2_busy  = busy[rs2_index];
  assign sb_empty  = (busy == 32'd0) && !b_valid && !vld_p1;
  assign sel_rd    = grant_b ? b_rd   : a_rd;
  assign sel_data  = grant_b ? b_data : a_data;

  // Set is applied after clear so an issue to the index B is retiring keeps it busy.
  always_comb begin
    busy_nxt = busy;
    if (grant_b) busy_nxt[b_rd] = 1'b0;
    if (iss_valid && iss_ready) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= '0;
      busy       <= '0;
    end else begin
      busy <= busy_nxt;
      if (grant_b || !b_valid)
        starve_cnt <= '0;
      else if (grant_a && (starve_cnt != CNT_W'(STARVE_MAX)))
        starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Stage p1: registered register-file write; writes to x0 complete the handshake silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_p1  <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1 <= (grant_a || grant_b) && (sel_rd != 5'd0);
      if ((grant_a || grant_b) && (sel_rd != 5'd0)) begin
        rd_p1   <= sel_rd;
        data_p1 <= sel_data;
      end
    end
  end

  assign wb_en    = vld_p1;
  assign rd_index = rd_p1;
  assign wb_data  = data_p1;

endmodule

// File: tb/tb_rf_wb_scheduler.sv
// Directed bench for rf_wb_scheduler: reset, A path, starvation forcing, scoreboard, x0, mid-run reset.
module tb_rf_wb_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        a_valid, b_valid, iss_valid;
  logic        a_ready, b_ready, iss_ready;
  logic [4:0]  a_rd, b_rd, iss_rd, rs1_index, rs2_index, rd_index;
  logic [31:0] a_data, b_data, wb_data;
  logic        rs1_busy, rs2_busy, sb_empty, wb_en;
  int          checks = 0;
  int          errors = 0;

  rf_wb_scheduler #(.STARVE_MAX(4), .CNT_W(3)) dut (
    .clk(clk), .rst(rst),
    .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .rs1_index(rs1_index), .rs2_index(rs2_index), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .sb_empty(sb_empty), .wb_en(wb_en), .rd_index(rd_index), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; a_valid = 0; b_valid = 0; iss_valid = 0;
    a_rd = 0; b_rd = 0; iss_rd = 0; a_data = 0; b_data = 0; rs1_index = 0; rs2_index = 0;
    tick(); tick();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en got %b exp 0", wb_en); end
    checks++; if (rd_index !== 5'd0) begin errors++; $display("FAIL reset_rd_index got %0d exp 0", rd_index); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_a_ready got %b exp 1", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready got %b exp 0", b_ready); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready got %b exp 1", iss_ready); end
    checks++; if ({rs1_busy, rs2_busy} !== 2'b00) begin errors++; $display("FAIL reset_rs_busy got %b exp 00", {rs1_busy, rs2_busy}); end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL reset_sb_empty got %b exp 1", sb_empty); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_a_only();
    a_valid = 1; a_rd = 5'd5; a_data = 32'hDEADBEEF; #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL a_only_ready got %b exp 1", a_ready); end
    checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL a_only_b_ready got %b exp 0", b_ready); end
    tick();
    a_valid = 0; #1;
    checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL a_only_wb_en got %b exp 1", wb_en); end
    checks++; if (rd_index !== 5'd5) begin errors++; $display("FAIL a_only_rd got %0d exp 5", rd_index); end
    checks++; if (wb_data !== 32'hDEADBEEF) begin errors++; $display("FAIL a_only_data got %h exp deadbeef", wb_data); end
    checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL a_only_sb_empty_inflight got %b exp 0", sb_empty); end
    tick();
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL a_only_wb_en_drop got %b exp 0", wb_en); end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL a_only_sb_empty got %b exp 1", sb_empty); end
  endtask

  task automatic test_starvation();
    logic exp_b, prev_b;
    prev_b = 0;
    a_valid = 1; b_valid = 1; a_rd = 5'd1; b_rd = 5'd2; b_data = 32'h0000_0B0B;
    for (int i = 0; i < 10; i++) begin
      a_data = 32'h100 + i; #1;
      exp_b = (i % 5) == 4;
      checks++; if (a_ready !== !exp_b) begin errors++; $display("FAIL starve_a_ready cyc %0d got %b exp %b", i, a_ready, !exp_b); end
      checks++; if (b_ready !== exp_b) begin errors++; $display("FAIL starve_b_ready cyc %0d got %b exp %b", i, b_ready, exp_b); end
      if (i > 0) begin
        checks++;
        if (rd_index !== (prev_b ? 5'd2 : 5'd1) || wb_data !== (prev_b ? 32'hB0B : 32'h100 + i - 1)) begin
          errors++; $display("FAIL starve_wb cyc %0d got rd %0d data %h exp_b %b", i, rd_index, wb_data, prev_b);
        end
      end
      prev_b = exp_b;
      tick();
    end
    a_valid = 0; b_valid = 0; #1;
    checks++; if (rd_index !== 5'd2 || wb_data !== 32'hB0B) begin errors++; $display("FAIL starve_last_b got rd %0d data %h exp 2 b0b", rd_index, wb_data); end
    tick();
  endtask

  task automatic test_scoreboard();
    iss_valid = 1; iss_rd = 5'd7; rs1_index = 5'd7; #1;
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL sb_iss_ready got %b exp 1", iss_ready); end
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_rs1_pre got %b exp 0", rs1_busy); end
    tick();
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_rs1_set got %b exp 1", rs1_busy); end
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL sb_reissue_ready got %b exp 0", iss_ready); end
    checks++; if (sb_empty !== 1'b0) begin errors++; $display("FAIL sb_empty_busy got %b exp 0", sb_empty); end
    iss_valid = 0; b_valid = 1; b_rd = 5'd7; b_data = 32'h77; #1;
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL sb_b_only_ready got %b exp 1", b_ready); end
    checks++; if (rs1_busy !== 1'b1) begin errors++; $display("FAIL sb_rs1_same_cycle got %b exp 1", rs1_busy); end
    tick();
    b_valid = 0; #1;
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL sb_rs1_clear got %b exp 0", rs1_busy); end
    checks++; if (wb_en !== 1'b1 || rd_index !== 5'd7 || wb_data !== 32'h77) begin errors++; $display("FAIL sb_b_write got en %b rd %0d data %h exp 1 7 77", wb_en, rd_index, wb_data); end
    tick();
  endtask

  task automatic test_set_wins();
    iss_valid = 1; iss_rd = 5'd9; b_valid = 1; b_rd = 5'd9; b_data = 32'h99; rs2_index = 5'd9; #1;
    checks++; if (iss_ready !== 1'b1 || b_ready !== 1'b1) begin errors++; $display("FAIL setwins_ready got iss %b b %b exp 1 1", iss_ready, b_ready); end
    tick();
    iss_valid = 0; b_valid = 0; #1;
    checks++; if (rs2_busy !== 1'b1) begin errors++; $display("FAIL setwins_busy got %b exp 1", rs2_busy); end
    b_valid = 1; tick();
    b_valid = 0; #1;
    checks++; if (rs2_busy !== 1'b0) begin errors++; $display("FAIL setwins_clear got %b exp 0", rs2_busy); end
    tick();
  endtask

  task automatic test_rd_zero();
    a_valid = 1; a_rd = 5'd0; a_data = 32'h1234; #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL x0_a_ready got %b exp 1", a_ready); end
    tick();
    a_valid = 0; iss_valid = 1; iss_rd = 5'd0; rs1_index = 5'd0; #1;
    checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL x0_wb_en got %b exp 0", wb_en); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL x0_iss_ready got %b exp 1", iss_ready); end
    tick();
    iss_valid = 0; #1;
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL x0_busy got %b exp 0", rs1_busy); end
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL x0_sb_empty got %b exp 1", sb_empty); end
  endtask

  task automatic test_reset_mid();
    iss_valid = 1; iss_rd = 5'd3; rs1_index = 5'd3; tick();
    iss_valid = 0; a_valid = 1; b_valid = 1; a_rd = 5'd4; a_data = 32'h44; b_rd = 5'd5; b_data = 32'h55;
    tick(); tick(); tick();
    checks++; if (rs1_busy !== 1'b1 || wb_en !== 1'b1) begin errors++; $display("FAIL mid_pre got busy %b en %b exp 1 1", rs1_busy, wb_en); end
    rst = 0; tick();
    rst = 1; #1;
    checks++; if (rs1_busy !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", rs1_busy); end
    checks++; if (wb_en !== 1'b0 || rd_index !== 5'd0 || wb_data !== 32'd0) begin errors++; $display("FAIL mid_out got en %b rd %0d data %h exp 0 0 0", wb_en, rd_index, wb_data); end
    for (int i = 0; i < 5; i++) begin
      checks++; if (a_ready !== (i != 4)) begin errors++; $display("FAIL mid_starve cyc %0d got a_ready %b exp %b", i, a_ready, i != 4); end
      tick();
    end
    a_valid = 0; b_valid = 0; tick(); tick();
    checks++; if (sb_empty !== 1'b1) begin errors++; $display("FAIL mid_sb_empty got %b exp 1", sb_empty); end
  endtask

  initial begin
    test_reset();
    test_a_only();
    test_starvation();
    test_scoreboard();
    test_set_wins();
    test_rd_zero();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
